// File: rtl/vdp_reg_pkg.sv
// Shared VDP register-write types, used by the copper, this arbiter and the register file.
package vdp_reg_pkg;

    localparam int VDP_REG_ADDR_WIDTH = 6;
    localparam int VDP_REG_DATA_WIDTH = 16;

    typedef struct packed {
        logic [VDP_REG_ADDR_WIDTH-1:0] address;
        logic [VDP_REG_DATA_WIDTH-1:0] data;
    } vdp_reg_write_t;

    localparam int VDP_REG_WRITE_WIDTH = $bits(vdp_reg_write_t);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_HOST,
        GRANT_COPPER
    } vdp_grant_t;

endpackage

// File: rtl/vdp_reg_write_fifo.sv
// Synchronous FIFO buffering copper register writes; full/empty are judged on registered state.
module vdp_reg_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Merges host bus writes and buffered copper writes into the single register-file write port.
module vdp_reg_write_arbiter
    import vdp_reg_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int HOST_BURST_MAX = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [VDP_REG_ADDR_WIDTH-1:0] host_write_address,
    input  logic [VDP_REG_DATA_WIDTH-1:0] host_write_data,
    input  logic                          host_write_en,
    output logic                          host_write_ready,
    input  logic [VDP_REG_ADDR_WIDTH-1:0] copper_write_address,
    input  logic [VDP_REG_DATA_WIDTH-1:0] copper_write_data,
    input  logic                          copper_write_en,
    output logic                          copper_write_ready,
    output logic [VDP_REG_ADDR_WIDTH-1:0] reg_write_address,
    output logic [VDP_REG_DATA_WIDTH-1:0] reg_write_data,
    output logic                          reg_write_en,
    input  logic                          reg_write_ready,
    output logic                          copper_overflow,
    input  logic                          copper_overflow_clear
);

    localparam int BURST_W = $clog2(HOST_BURST_MAX + 1);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    vdp_reg_write_t     copper_in;
    vdp_reg_write_t     fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_count;
    logic [BURST_W-1:0] burst_count;
    logic               slot_loadable;
    logic               host_allowed;
    vdp_grant_t         grant;

    assign copper_in.address = copper_write_address;
    assign copper_in.data    = copper_write_data;

    vdp_reg_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (VDP_REG_WRITE_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (copper_write_en),
        .push_data (copper_in),
        .pop       (grant == GRANT_COPPER),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign slot_loadable      = !reg_write_en || reg_write_ready;
    assign host_allowed       = fifo_empty || (burst_count < BURST_W'(HOST_BURST_MAX));
    assign host_write_ready   = slot_loadable && host_allowed;
    assign copper_write_ready = !fifo_full;

    // Host has priority until it has used up its burst allowance against a waiting copper.
    always_comb begin
        grant = GRANT_NONE;
        if (slot_loadable) begin
            if (host_write_en && host_allowed) begin
                grant = GRANT_HOST;
            end else if (!fifo_empty) begin
                grant = GRANT_COPPER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_count <= '0;
        end else if (fifo_count == '0) begin
            burst_count <= '0;
        end else if (grant == GRANT_HOST) begin
            if (burst_count < BURST_W'(HOST_BURST_MAX)) begin
                burst_count <= burst_count + BURST_W'(1);
            end
        end else if (grant == GRANT_COPPER) begin
            burst_count <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_en      <= 1'b0;
            reg_write_address <= '0;
            reg_write_data    <= '0;
        end else if (slot_loadable) begin
            unique case (grant)
                GRANT_HOST: begin
                    reg_write_en      <= 1'b1;
                    reg_write_address <= host_write_address;
                    reg_write_data    <= host_write_data;
                end
                GRANT_COPPER: begin
                    reg_write_en      <= 1'b1;
                    reg_write_address <= fifo_head.address;
                    reg_write_data    <= fifo_head.data;
                end
                default: begin
                    reg_write_en <= 1'b0;
                end
            endcase
        end
    end

    // An overflow in the same cycle beats a clear so that no drop goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            copper_overflow <= 1'b0;
        end else if (copper_write_en && fifo_full) begin
            copper_overflow <= 1'b1;
        end else if (copper_overflow_clear) begin
            copper_overflow <= 1'b0;
        end
    end

endmodule
